// File: rtl/tft_pkg.sv
// Shared definitions for the TFT display sequencer.
//   - FSM state encoding for panel bring-up
//   - pixel source encodings (what cur_src reports)
//   - RGB565 colour-bar constants and a bar-index to colour lookup
package tft_pkg;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,   // waiting for lock and the first frame start
    S_BLANK = 2'd1,   // black frames before the backlight comes on
    S_RUN   = 2'd2    // normal display, backlight ramping/holding
  } state_e;

  localparam logic [1:0] SRC_IMG  = 2'd0;
  localparam logic [1:0] SRC_BAR  = 2'd1;
  localparam logic [1:0] SRC_FILL = 2'd2;

  localparam logic [15:0] C_WHITE   = 16'hFFFF;
  localparam logic [15:0] C_YELLOW  = 16'hFFE0;
  localparam logic [15:0] C_CYAN    = 16'h07FF;
  localparam logic [15:0] C_GREEN   = 16'h07E0;
  localparam logic [15:0] C_MAGENTA = 16'hF81F;
  localparam logic [15:0] C_RED     = 16'hF800;
  localparam logic [15:0] C_BLUE    = 16'h001F;
  localparam logic [15:0] C_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tft_pwm_gen.sv
// Backlight PWM generator.
//   clk, rst_n : pixel clock, async active-low reset
//   duty       : high time in counts of 256 (0 = always low, 255 = 255/256)
//   en         : forces the output low when 0
//   pwm        : PWM output
module tft_pwm_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty,
  input  logic       en,
  output logic       pwm
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Strict less-than: a duty of 255 leaves the cnt=255 slot low.
  assign pwm = en & (cnt_q < duty);

endmodule

// File: rtl/tft_disp_seq.sv
// TFT display sequencer, pixel-clock domain.
// Sits between the timing generator and the panel: brings the panel up after
// PLL lock (blank frames, then a soft-start backlight), selects the pixel
// source frame-synchronously and drives the backlight PWM.
//   clk9M, rst_n          : pixel clock, async active-low reset
//   pll_locked            : asynchronous lock indication (synchronised here)
//   tft_vs, tft_de, hcnt  : timing generator (vs active-low)
//   img_data              : image pixel, valid with tft_de
//   bright                : target backlight duty
//   auto_cycle            : rotate sources every DWELL_FRAMES frames
//   sel_vld, sel_src      : manual source request (src 3 ignored)
//   pix_out, de_out       : registered pixel and matching data enable
//   tft_pwm, bl_en        : backlight PWM and enable
//   cur_src               : source being displayed
//   dbg_state             : FSM state
//   dbg_hcnt_err          : hcnt did not advance by one inside an active run
// Handshake: sel_vld is a single-cycle strobe with no ready; sel_src is
// sampled only in the cycle sel_vld is high.
module tft_disp_seq
  import tft_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 480,
  parameter int unsigned BLANK_FRAMES = 2,
  parameter int unsigned DWELL_FRAMES = 120,
  parameter logic [15:0] FILL_COLOR   = 16'h001F
) (
  input  logic        clk9M,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic        tft_vs,
  input  logic        tft_de,
  input  logic [9:0]  hcnt,
  input  logic [15:0] img_data,
  input  logic [7:0]  bright,
  input  logic        auto_cycle,
  input  logic        sel_vld,
  input  logic [1:0]  sel_src,
  output logic [15:0] pix_out,
  output logic        de_out,
  output logic        tft_pwm,
  output logic        bl_en,
  output logic [1:0]  cur_src,
  output logic [1:0]  dbg_state,
  output logic        dbg_hcnt_err
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int unsigned BLK_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam int unsigned DWL_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [COL_W-1:0] BAR_LAST   = COL_W'(BAR_W - 1);
  localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'(BLANK_FRAMES - 1);
  localparam logic [DWL_W-1:0] DWELL_LAST = DWL_W'(DWELL_FRAMES - 1);

  state_e state_q, state_d;

  logic             lock_s1_q, lock_s1_d;
  logic             lock_s2_q, lock_s2_d;
  logic             vs_q, vs_d;
  logic             fs_q, fs_d;
  logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [1:0]       cur_src_q, cur_src_d;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_src_q, pend_src_d;
  logic [DWL_W-1:0] dwell_q, dwell_d;
  logic [7:0]       duty_q, duty_d;
  logic             de_q, de_d;
  logic [15:0]      pix_q, pix_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0]       bar_q, bar_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic             hcnt_err_q, hcnt_err_d;

  logic             locked;
  logic             run;
  logic             de_rise;
  logic [2:0]       cur_bar;
  logic [COL_W-1:0] col_cur;

  always_comb begin
    locked  = lock_s2_q;
    run     = (state_q == S_RUN) && locked;
    de_rise = tft_de & ~de_q;
    cur_bar = de_rise ? 3'd0 : bar_q;
    col_cur = de_rise ? '0 : col_q;

    lock_s1_d = pll_locked;
    lock_s2_d = lock_s1_q;
    vs_d      = tft_vs;
    // Falling edge of vs seen against the previous registered sample.
    fs_d      = vs_q & ~tft_vs;

    // Bring-up FSM.
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    case (state_q)
      S_WAIT: begin
        if (fs_q) begin
          state_d     = S_BLANK;
          blank_cnt_d = '0;
        end
      end
      S_BLANK: begin
        if (fs_q) begin
          if (blank_cnt_q == BLANK_LAST) begin
            state_d = S_RUN;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_WAIT;
    endcase
    if (!locked) begin
      state_d     = S_WAIT;
      blank_cnt_d = '0;
    end

    // Backlight soft start: one step per frame toward the target.
    duty_d = duty_q;
    if (fs_q && (state_q == S_RUN)) begin
      if (duty_q < bright) begin
        duty_d = duty_q + 8'd1;
      end else if (duty_q > bright) begin
        duty_d = duty_q - 8'd1;
      end
    end
    if (!locked) begin
      duty_d = 8'd0;
    end

    // Source selection, only ever changing at a frame start.
    cur_src_d  = cur_src_q;
    pend_vld_d = pend_vld_q;
    pend_src_d = pend_src_q;
    dwell_d    = dwell_q;
    if (fs_q) begin
      if (pend_vld_q) begin
        cur_src_d  = pend_src_q;
        dwell_d    = '0;
        pend_vld_d = 1'b0;
      end else if (auto_cycle && (dwell_q >= DWELL_LAST)) begin
        cur_src_d = (cur_src_q == SRC_FILL) ? SRC_IMG : cur_src_q + 2'd1;
        dwell_d   = '0;
      end else if (dwell_q != '1) begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    // A request arriving with fs is latched after the fs update, so it
    // waits for the following frame.
    if (sel_vld && (sel_src != 2'd3)) begin
      pend_vld_d = 1'b1;
      pend_src_d = sel_src;
    end
    if (!locked) begin
      pend_vld_d = 1'b0;
    end

    // Colour-bar column tracking, restarted on every DE rise.
    col_d = col_q;
    bar_d = bar_q;
    if (tft_de) begin
      if (col_cur == BAR_LAST) begin
        col_d = '0;
        bar_d = (cur_bar == 3'd7) ? 3'd7 : cur_bar + 3'd1;
      end else begin
        col_d = col_cur + 1'b1;
        bar_d = cur_bar;
      end
    end

    // Pixel mux.
    de_d  = tft_de;
    pix_d = 16'h0000;
    if (run && tft_de) begin
      case (cur_src_q)
        SRC_IMG:  pix_d = img_data;
        SRC_BAR:  pix_d = bar_color(cur_bar);
        SRC_FILL: pix_d = FILL_COLOR;
        default:  pix_d = 16'h0000;
      endcase
    end

    hcnt_d     = hcnt;
    hcnt_err_d = tft_de & de_q & (hcnt != (hcnt_q + 10'd1));
  end

  always_ff @(posedge clk9M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk9M or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1_q   <= 1'b0;
      lock_s2_q   <= 1'b0;
      vs_q        <= 1'b1;
      fs_q        <= 1'b0;
      blank_cnt_q <= '0;
      cur_src_q   <= SRC_IMG;
      pend_vld_q  <= 1'b0;
      pend_src_q  <= 2'd0;
      dwell_q     <= '0;
      duty_q      <= 8'd0;
      de_q        <= 1'b0;
      pix_q       <= 16'h0000;
      col_q       <= '0;
      bar_q       <= 3'd0;
      hcnt_q      <= 10'd0;
      hcnt_err_q  <= 1'b0;
    end else begin
      lock_s1_q   <= lock_s1_d;
      lock_s2_q   <= lock_s2_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
      blank_cnt_q <= blank_cnt_d;
      cur_src_q   <= cur_src_d;
      pend_vld_q  <= pend_vld_d;
      pend_src_q  <= pend_src_d;
      dwell_q     <= dwell_d;
      duty_q      <= duty_d;
      de_q        <= de_d;
      pix_q       <= pix_d;
      col_q       <= col_d;
      bar_q       <= bar_d;
      hcnt_q      <= hcnt_d;
      hcnt_err_q  <= hcnt_err_d;
    end
  end

  // Losing lock blanks the panel and backlight in the same cycle the
  // synchronised lock drops, ahead of the registered state catching up.
  assign pix_out      = lock_s2_q ? pix_q : 16'h0000;
  assign bl_en        = (state_q == S_RUN) && lock_s2_q;
  assign de_out       = de_q;
  assign cur_src      = cur_src_q;
  assign dbg_state    = state_q;
  assign dbg_hcnt_err = hcnt_err_q;

  tft_pwm_gen u_pwm (
    .clk   (clk9M),
    .rst_n (rst_n),
    .duty  (duty_q),
    .en    (bl_en),
    .pwm   (tft_pwm)
  );

endmodule
